// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : sequencer state encodings, condition constants and opcode classes
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_EXEC1    = 3'd1,
    ST_EXEC2    = 3'd2,
    ST_MUL_WAIT = 3'd3,
    ST_IRQ      = 3'd4,
    ST_HALT     = 3'd5
  } seq_state_e;

  localparam logic [1:0] PH_FETCH = 2'b00;
  localparam logic [1:0] PH_EXEC1 = 2'b01;
  localparam logic [1:0] PH_EXEC2 = 2'b10;
  localparam logic [1:0] PH_OTHER = 2'b11;

  localparam logic [3:0] COND_ALWAYS = 4'b0110;

  localparam logic [1:0]  PAT_MUL  = 2'b10;
  localparam logic [11:0] PAT_STP  = 12'hF01;
  localparam logic [11:0] PAT_RTN  = 12'hF00;
  localparam logic [8:0]  PAT_LDI  = 9'b000001010;
  localparam logic [8:0]  PAT_AIM  = 9'b000001011;
  localparam logic [8:0]  PAT_SIM  = 9'b000001100;
  localparam logic [5:0]  PAT_LOAD = 6'b011001;
  localparam logic [5:0]  PAT_POP  = 6'b011010;

  function automatic logic is_mul(input logic [15:0] b);
    return b[15:14] == PAT_MUL;
  endfunction

  function automatic logic is_stp(input logic [15:0] b);
    return b[15:4] == PAT_STP;
  endfunction

  // Immediate-style EXEC2 ops that also consume an extra instruction word
  function automatic logic is_exec2_pc(input logic [15:0] b);
    return (b[15:7] == PAT_LDI) || (b[15:7] == PAT_AIM) || (b[15:7] == PAT_SIM);
  endfunction

  function automatic logic needs_exec2(input logic [15:0] b);
    return is_exec2_pc(b) || (b[15:10] == PAT_LOAD) || (b[15:10] == PAT_POP)
           || (b[15:4] == PAT_RTN);
  endfunction

  function automatic logic [3:0] cond_field(input logic [15:0] b);
    logic [3:0] c;
    c = COND_ALWAYS;
    casez (b[15:11])
      5'b000??: c = b[6:3];
      5'b001??: c = b[10:7];
      5'b01???: c = b[9:6];
      5'b10???: c = b[12:9];
      5'b110??: c = COND_ALWAYS;
      5'b1110?: c = COND_ALWAYS;
      5'b11110: c = b[3:0];
      default:  c = b[6:3];
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cond_evaluator.sv
// ============================================================================
// cond_evaluator : extracts the condition field and tests it against status
// Revision: 1.0
// ============================================================================
`default_nettype none

module cond_evaluator
  import cpu_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int STATUS_W = 8
) (
  input  logic [INSTR_W-1:0]  instruction_i,
  input  logic [STATUS_W-1:0] status_i,
  output logic                cond_pass_o
);

  logic [15:0] opc_w;
  logic [3:0]  code_w;
  logic [7:0]  flags_w;
  logic        flag_w;

  assign opc_w   = instruction_i[INSTR_W-1 -: 16];
  assign code_w  = cond_field(opc_w);
  assign flags_w = status_i[7:0];
  assign flag_w  = flags_w[code_w[2:0]];

  // Codes 0110 and 1110 are both unconditional rather than a flag test
  always_comb begin
    cond_pass_o = 1'b1;
    if (code_w[2:0] != COND_ALWAYS[2:0]) begin
      cond_pass_o = code_w[3] ? ~flag_w : flag_w;
    end
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer : fetch/execute phase FSM with wait states, MUL, HALT, IRQ
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int STATUS_W   = 8,
  parameter int MUL_CYCLES = 1,
  parameter int IRQ_BIT    = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic [STATUS_W-1:0] status_reg,
  input  logic                stack_overflow,
  input  logic                mem_ready,
  input  logic                irq_req,
  output logic [1:0]          state,
  output logic                ir_load,
  output logic                pc_cnt_en,
  output logic                cond_pass,
  output logic                mul_busy,
  output logic                irq_ack,
  output logic                halted
);

  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_INIT  = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

  seq_state_e  state_q, state_d;
  logic [3:0]  mul_cnt_q, mul_cnt_d;
  logic [15:0] opc_w;
  logic        is_mul_w, is_stp_w, needs_exec2_w, is_exec2_pc_w;
  seq_state_e  exit_state_w;

  cond_evaluator #(
    .INSTR_W  (INSTR_W),
    .STATUS_W (STATUS_W)
  ) u_cond_evaluator (
    .instruction_i (instruction),
    .status_i      (status_reg),
    .cond_pass_o   (cond_pass)
  );

  assign opc_w         = instruction[INSTR_W-1 -: 16];
  assign is_mul_w      = is_mul(opc_w);
  assign is_stp_w      = is_stp(opc_w);
  assign needs_exec2_w = needs_exec2(opc_w);
  assign is_exec2_pc_w = is_exec2_pc(opc_w);

  // Interrupts are only considered on the cycle an instruction completes
  assign exit_state_w = (irq_req && status_reg[IRQ_BIT]) ? ST_IRQ : ST_FETCH;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      mul_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    ir_load   = 1'b0;
    pc_cnt_en = 1'b0;
    mul_busy  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          ir_load   = 1'b1;
          pc_cnt_en = 1'b1;
          state_d   = ST_EXEC1;
        end
      end

      ST_EXEC1: begin
        pc_cnt_en = ~is_stp_w;
        mul_busy  = is_mul_w;
        if ((is_stp_w || stack_overflow) && cond_pass) begin
          state_d = ST_HALT;
        end else if (is_mul_w && MUL_MULTI) begin
          state_d   = ST_MUL_WAIT;
          mul_cnt_d = MUL_INIT;
        end else if (needs_exec2_w) begin
          state_d = ST_EXEC2;
        end else begin
          state_d = exit_state_w;
        end
      end

      ST_MUL_WAIT: begin
        mul_busy = 1'b1;
        if (mul_cnt_q == 4'd0) begin
          state_d = exit_state_w;
        end else begin
          mul_cnt_d = mul_cnt_q - 4'd1;
        end
      end

      ST_EXEC2: begin
        if (mem_ready) begin
          pc_cnt_en = is_exec2_pc_w;
          state_d   = exit_state_w;
        end
      end

      ST_IRQ:  state_d = ST_FETCH;

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    state = PH_OTHER;
    case (state_q)
      ST_FETCH: state = PH_FETCH;
      ST_EXEC1: state = PH_EXEC1;
      ST_EXEC2: state = PH_EXEC2;
      default:  state = PH_OTHER;
    endcase
  end

  assign irq_ack = (state_q == ST_IRQ);
  assign halted  = (state_q == ST_HALT);

endmodule

`default_nettype wire
